// File: rtl/aqp_handctrl_emu.sv
// Hand-controller emulator: two cascaded 8-bit PISO shift registers ('165 style)
// presented on the serial controller port. Reader strobes arrive asynchronously
// and are synchronized into the clk domain before use. Also reports frame and
// link status for the host.
module aqp_handctrl_emu #(
  parameter int   SYNC_STAGES    = 2,
  parameter int   TIMEOUT_CYCLES = 16384,
  parameter logic FILL_BIT       = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hctrl_clk,
  input  logic       hctrl_load_n,
  output logic       hctrl_data,
  input  logic [7:0] hctrl1_in,
  input  logic [7:0] hctrl2_in,
  output logic       frame_strobe,
  output logic [7:0] frame_count,
  output logic       overrun,
  output logic       link_active
);

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
  localparam logic [4:0]  SHIFT_MAX   = 5'd17;
  localparam logic [4:0]  SHIFT_FULL  = 5'd16;

  logic [SYNC_STAGES-1:0] clk_sync_r;
  logic [SYNC_STAGES-1:0] load_sync_r;
  logic                   clk_prev_r;
  logic                   load_prev_r;
  logic                   clk_s;
  logic                   load_s;
  logic                   clk_rise_s;
  logic                   load_rise_s;
  logic                   load_fall_s;

  logic [15:0]            chain_r;
  logic [4:0]             shift_cnt_r;
  logic                   hctrl_data_r;
  logic                   overrun_r;
  logic                   frame_strobe_r;
  logic [7:0]             frame_count_r;
  logic                   link_active_r;
  logic [15:0]            timeout_cnt_r;
  logic [15:0]            timeout_next_s;

  // Synchronizers reset to the idle bus state (clock low, load released) so
  // leaving reset never looks like a load edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_r  <= '0;
      load_sync_r <= '1;
      clk_prev_r  <= 1'b0;
      load_prev_r <= 1'b1;
    end else begin
      clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], hctrl_clk};
      load_sync_r <= {load_sync_r[SYNC_STAGES-2:0], hctrl_load_n};
      clk_prev_r  <= clk_s;
      load_prev_r <= load_s;
    end
  end

  // Edge detection on the synchronized strobes; saturating timeout increment.
  always_comb begin
    clk_s       = clk_sync_r[SYNC_STAGES-1];
    load_s      = load_sync_r[SYNC_STAGES-1];
    clk_rise_s  = clk_s & ~clk_prev_r;
    load_rise_s = load_s & ~load_prev_r;
    load_fall_s = ~load_s & load_prev_r;
    if (timeout_cnt_r == TIMEOUT_LIM) begin
      timeout_next_s = timeout_cnt_r;
    end else begin
      timeout_next_s = timeout_cnt_r + 16'd1;
    end
  end

  // Shift chain: level-sensitive parallel load has priority over a shift edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain_r      <= 16'hFFFF;
      shift_cnt_r  <= 5'd0;
      overrun_r    <= 1'b0;
      hctrl_data_r <= 1'b1;
    end else begin
      hctrl_data_r <= chain_r[15];
      if (!load_s) begin
        chain_r     <= {hctrl2_in, hctrl1_in};
        shift_cnt_r <= 5'd0;
        overrun_r   <= 1'b0;
      end else if (clk_rise_s) begin
        chain_r <= {chain_r[14:0], FILL_BIT};
        if (shift_cnt_r == SHIFT_FULL) begin
          overrun_r <= 1'b1;
        end else begin
          overrun_r <= overrun_r;
        end
        if (shift_cnt_r != SHIFT_MAX) begin
          shift_cnt_r <= shift_cnt_r + 5'd1;
        end else begin
          shift_cnt_r <= shift_cnt_r;
        end
      end else begin
        chain_r     <= chain_r;
        shift_cnt_r <= shift_cnt_r;
        overrun_r   <= overrun_r;
      end
    end
  end

  // Frame bookkeeping: a completed load is the rising edge of the synced load_n.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_strobe_r <= 1'b0;
      frame_count_r  <= 8'd0;
    end else begin
      frame_strobe_r <= load_rise_s;
      if (load_rise_s) begin
        frame_count_r <= frame_count_r + 8'd1;
      end else begin
        frame_count_r <= frame_count_r;
      end
    end
  end

  // Link watchdog: restarted by each load start, drops after TIMEOUT_CYCLES.
  always_ff @(posedge clk) begin
    if (reset) begin
      link_active_r <= 1'b0;
      timeout_cnt_r <= 16'd0;
    end else if (load_fall_s) begin
      link_active_r <= 1'b1;
      timeout_cnt_r <= 16'd0;
    end else begin
      timeout_cnt_r <= timeout_next_s;
      if (timeout_next_s == TIMEOUT_LIM) begin
        link_active_r <= 1'b0;
      end else begin
        link_active_r <= link_active_r;
      end
    end
  end

  assign hctrl_data   = hctrl_data_r;
  assign frame_strobe = frame_strobe_r;
  assign frame_count  = frame_count_r;
  assign overrun      = overrun_r;
  assign link_active  = link_active_r;

endmodule

// File: tb/tb_aqp_handctrl_emu.sv
// Scoreboard bench for aqp_handctrl_emu: stimulus pushes expected values,
// monitors pop and compare on the falling clk edge.
module tb_aqp_handctrl_emu;

  localparam int K_DATA = 0;
  localparam int K_FC   = 1;
  localparam int K_OVR  = 2;
  localparam int K_LINK = 3;
  localparam int K_STB  = 4;

  typedef struct {
    int         kind;
    logic [7:0] val;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hctrl_clk = 1'b0;
  logic       hctrl_load_n = 1'b1;
  logic       hctrl_data;
  logic [7:0] hctrl1_in = 8'h00;
  logic [7:0] hctrl2_in = 8'h00;
  logic       frame_strobe;
  logic [7:0] frame_count;
  logic       overrun;
  logic       link_active;

  exp_t       exp_q[$];
  logic [7:0] strobe_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] model_fc = 8'd0;

  aqp_handctrl_emu #(
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(1000),
    .FILL_BIT(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hctrl_clk(hctrl_clk),
    .hctrl_load_n(hctrl_load_n),
    .hctrl_data(hctrl_data),
    .hctrl1_in(hctrl1_in),
    .hctrl2_in(hctrl2_in),
    .frame_strobe(frame_strobe),
    .frame_count(frame_count),
    .overrun(overrun),
    .link_active(link_active)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  // Monitor: drain pending expectations against DUT outputs.
  always @(negedge clk) begin
    logic [7:0] act;
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.kind)
        K_DATA:  act = {7'd0, hctrl_data};
        K_FC:    act = frame_count;
        K_OVR:   act = {7'd0, overrun};
        K_LINK:  act = {7'd0, link_active};
        K_STB:   act = {7'd0, frame_strobe};
        default: act = 8'hXX;
      endcase
      n_vec++;
      if (act !== e.val) begin
        n_err++;
        $display("FAIL %s: got %0h, expected %0h", e.name, act, e.val);
      end
    end
  end

  // Strobe monitor: every frame_strobe pulse must match a completed load.
  always @(negedge clk) begin
    logic [7:0] exp_fc;
    if (frame_strobe === 1'b1) begin
      n_vec++;
      if (strobe_q.size() == 0) begin
        n_err++;
        $display("FAIL spurious_strobe: got strobe with count %0d, expected none", frame_count);
      end else begin
        exp_fc = strobe_q.pop_front();
        if (frame_count !== exp_fc) begin
          n_err++;
          $display("FAIL strobe_count: got %0d, expected %0d", frame_count, exp_fc);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input int kind, input logic [7:0] v, input string nm);
    exp_t e;
    e.kind = kind;
    e.val  = v;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic end_load();
    hctrl_load_n = 1'b1;
    model_fc = model_fc + 8'd1;
    strobe_q.push_back(model_fc);
  endtask

  task automatic do_load(input logic [7:0] p2, input logic [7:0] p1, input int len);
    hctrl2_in    = p2;
    hctrl1_in    = p1;
    hctrl_load_n = 1'b0;
    cyc(len);
    end_load();
    cyc(128);
  endtask

  // Sample the current bit, then give one full hctrl_clk period.
  task automatic sample_period(input logic exp_bit, input string nm);
    chk(K_DATA, {7'd0, exp_bit}, nm);
    hctrl_clk = 1'b1;
    cyc(128);
    hctrl_clk = 1'b0;
    cyc(128);
  endtask

  task automatic run_frame(input logic [7:0] p2, input logic [7:0] p1, input string tag);
    logic [15:0] word;
    word = {p2, p1};
    do_load(p2, p1, 256);
    for (int i = 0; i < 16; i++) begin
      sample_period(word[15-i], $sformatf("%s_bit%0d", tag, i));
    end
  endtask

  initial begin
    // Reset
    reset = 1'b1;
    cyc(4);
    chk(K_DATA, 8'd1, "rst_data");
    chk(K_FC,   8'd0, "rst_fc");
    chk(K_OVR,  8'd0, "rst_ovr");
    chk(K_LINK, 8'd0, "rst_link");
    chk(K_STB,  8'd0, "rst_strobe");
    reset = 1'b0;
    cyc(10);
    chk(K_DATA, 8'd1, "post_rst_data");

    // Frame 3C/A5, then 17th shift for overrun
    run_frame(8'h3C, 8'hA5, "frame");
    chk(K_FC,  model_fc, "frame_fc");
    chk(K_OVR, 8'd0, "ovr_at16");
    sample_period(1'b1, "fill_bit17");
    chk(K_OVR, 8'd1, "ovr_after17");
    chk(K_DATA, 8'd1, "data_after17");

    // Load versus edge: clock rises while load is held low
    hctrl2_in    = 8'h5A;
    hctrl1_in    = 8'h96;
    hctrl_load_n = 1'b0;
    cyc(250);
    hctrl_clk = 1'b1;
    cyc(6);
    chk(K_OVR, 8'd0, "ovr_cleared_by_load");
    end_load();
    cyc(128);
    chk(K_DATA, 8'd0, "lve_bit7");
    hctrl_clk = 1'b0;
    cyc(128);
    chk(K_DATA, 8'd0, "lve_noshift");
    hctrl_clk = 1'b1;
    cyc(128);
    chk(K_DATA, 8'd1, "lve_bit6");
    hctrl_clk = 1'b0;
    cyc(128);

    // Steady load: data follows hctrl2_in[7]
    hctrl_load_n = 1'b0;
    hctrl2_in    = 8'h80;
    cyc(8);
    chk(K_DATA, 8'd1, "steady_hi");
    hctrl2_in = 8'h7F;
    cyc(8);
    chk(K_DATA, 8'd0, "steady_lo");
    end_load();
    cyc(20);

    // Link timeout
    cyc(1100);
    chk(K_LINK, 8'd0, "link_idle");
    hctrl_load_n = 1'b0;
    cyc(20);
    chk(K_LINK, 8'd1, "link_set");
    end_load();
    cyc(970);
    chk(K_LINK, 8'd1, "link_before_to");
    cyc(20);
    chk(K_LINK, 8'd0, "link_timed_out");
    hctrl_load_n = 1'b0;
    cyc(10);
    chk(K_LINK, 8'd1, "link_reset");
    end_load();
    cyc(20);

    // Mid-frame reset after 5 shifts
    do_load(8'h12, 8'h34, 256);
    for (int i = 0; i < 5; i++) begin
      hctrl_clk = 1'b1;
      cyc(128);
      hctrl_clk = 1'b0;
      cyc(128);
    end
    reset = 1'b1;
    cyc(4);
    model_fc = 8'd0;
    chk(K_DATA, 8'd1, "mid_rst_data");
    chk(K_FC,   8'd0, "mid_rst_fc");
    chk(K_LINK, 8'd0, "mid_rst_link");
    reset = 1'b0;
    cyc(10);
    chk(K_DATA, 8'd1, "mid_post_data");
    run_frame(8'hFF, 8'h00, "midrst");
    chk(K_FC, model_fc, "midrst_fc");

    cyc(4);
    n_vec++;
    if (strobe_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_strobe: got %0d unmatched loads, expected 0", strobe_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aqp_handctrl_emu.md
Name: aqp_handctrl_emu

Overview:
Emulates the external hand-controller hardware: two cascaded 8-bit parallel-in/serial-out shift registers ('165 style) behind the serial controller port. It is driven by the system-side controller reader's hctrl_clk and hctrl_load_n, and returns hctrl_data. Button state comes from on-chip sources (ESP32 gamepad bridge, keyboard mapping), so a console with no physical hand controllers still presents valid data. It also reports link status for the host.

Parameters:
SYNC_STAGES, 2, number of flip-flops in each input synchronizer (minimum 2).
TIMEOUT_CYCLES, 16384, clk cycles without a load pulse before link_active drops (must be less than 65536).
FILL_BIT, 1'b1, serial input of the chain; shifted into chain[0] on every shift.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
hctrl_clk  input  1  serial shift clock from the reader; asynchronous to clk
hctrl_load_n  input  1  parallel load, active low; asynchronous to clk
hctrl_data  output  1  serial data to the reader; registered
hctrl1_in  input  8  port-1 button byte, active low; sampled during load
hctrl2_in  input  8  port-2 button byte, active low; sampled during load
frame_strobe  output  1  one-cycle pulse when a load ends (synchronized load_n rises)
frame_count  output  8  number of completed loads, wraps 255->0
overrun  output  1  sticky: more than 16 shifts since the last load
link_active  output  1  a load was seen within the last TIMEOUT_CYCLES cycles

Behaviour:
- Reset values: chain=16'hFFFF, hctrl_data=1, frame_strobe=0, frame_count=0, overrun=0, link_active=0, shift count=0, timeout counter=0. Synchronizers reset to idle: hctrl_clk=0, hctrl_load_n=1.
- Synchronization: hctrl_clk and hctrl_load_n each pass through SYNC_STAGES flip-flops. One more register holds the previous synchronized value for edge detection. All logic below uses only the synchronized signals.
- Chain layout: chain[15:8]=port 2, chain[7:0]=port 1. hctrl_data is registered and equals chain[15].
- Load: on each clk cycle with load_s=0, chain<={hctrl2_in,hctrl1_in} and shift count<=0. This is level-sensitive, so the value captured is the input on the last cycle of the load.
- Shift: on a rising edge of clk_s while load_s=1, chain<={chain[14:0],FILL_BIT} and the shift count increments, saturating at 17.
- Load and clock edge together: load wins and no shift occurs.
- Latency: from an input pin edge to the new hctrl_data is at most SYNC_STAGES+2 clk cycles. The reader holds hctrl_clk for 128 clk per phase, so the data settles well before the reader samples it.
- Bit order: the first bit presented after a load is chain[15] (port-2 bit 7). The 16th bit is port-1 bit 0. Every later bit equals FILL_BIT.
- overrun: set when the shift count would pass 16 (17th shift edge since the last load). Cleared only by a load or by reset.
- frame_strobe and frame_count: on a rising edge of load_s, frame_strobe=1 for one cycle and frame_count increments mod 256.
- link_active: set to 1 and the timeout counter cleared on a falling edge of load_s. Otherwise the counter increments, saturating. When the counter reaches TIMEOUT_CYCLES, link_active goes to 0.
- Reset mid-frame: all state returns to reset values and the current frame is abandoned. hctrl_data=1 until the next load. No spurious frame_strobe is produced at reset release, because the synchronizers reset to idle.
- Steady load (load_n held low): the chain tracks the inputs every cycle, hctrl_data follows hctrl2_in[7], and no frame_strobe is produced.

Test Plan:
- Reset: assert reset for 4 cycles -> hctrl_data=1, frame_count=0, overrun=0, link_active=0, frame_strobe=0.
- Frame: hctrl2_in=8'h3C, hctrl1_in=8'hA5. Drive a 256-clk load pulse, then 16 hctrl_clk periods of 256 clk, sampling on each falling edge -> bits 0,0,1,1,1,1,0,0,1,0,1,0,0,1,0,1. frame_count=1 and exactly one frame_strobe.
- Overrun: same as the frame test, then a 17th clock period -> hctrl_data=1 and overrun=1. The next load clears overrun to 0.
- Load versus edge: raise hctrl_clk on the same clk as the load is held low -> no shift; the first sampled bit is still hctrl2_in[7].
- Timeout (TIMEOUT_CYCLES=1000): one load, then idle -> link_active=1 after the load, and 0 once 1000 cycles have elapsed since the load's falling edge. A new load sets it back to 1.
- Mid-frame reset: assert reset after 5 shifts, then run a full frame with inputs 8'hFF/8'h00 -> received bytes port 2=8'hFF, port 1=8'h00, and frame_count=1.
